// File: rtl/id_scoreboard_pkg.sv
// Shared types and constants for the LC-3b decode-stage register scoreboard.
package id_scoreboard_pkg;

    localparam int NUM_REGS  = 8;
    localparam int CNT_WIDTH = 2;

    typedef logic [2:0]           lc3b_reg;
    typedef logic [CNT_WIDTH-1:0] lc3b_sb_cnt;

    localparam lc3b_sb_cnt SB_CNT_MAX = '1;

endpackage

// File: rtl/sb_counter.sv
// One saturating pending-write counter: +inc, -dec (0..2), with an error
// pulse whenever the net result would leave the representable range.
module sb_counter
    import id_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic [1:0] dec,
    output lc3b_sb_cnt cnt,
    output logic       nz,
    output logic       err_pulse
);

    // Two extra bits so the sum and the difference never wrap before compare.
    logic [CNT_WIDTH+1:0] sum;
    logic [CNT_WIDTH+1:0] dec_w;
    logic [CNT_WIDTH+1:0] max_w;
    lc3b_sb_cnt           cnt_next;

    always_comb begin
        sum       = {2'b00, cnt} + {{(CNT_WIDTH+1){1'b0}}, inc};
        dec_w     = {{CNT_WIDTH{1'b0}}, dec};
        max_w     = {2'b00, SB_CNT_MAX};
        cnt_next  = cnt;
        err_pulse = 1'b0;
        if (sum < dec_w) begin
            cnt_next  = '0;
            err_pulse = 1'b1;
        end else if ((sum - dec_w) > max_w) begin
            cnt_next  = SB_CNT_MAX;
            err_pulse = 1'b1;
        end else begin
            cnt_next  = lc3b_sb_cnt'(sum - dec_w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign nz = (cnt != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: counts in-flight writes per register and stalls
// decode on a read of a pending register or when the destination counter is full.
module id_scoreboard
    import id_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_load_dest,
    input  lc3b_reg             issue_dest,
    input  logic                src_a_used,
    input  lc3b_reg             src_a,
    input  logic                src_b_used,
    input  lc3b_reg             src_b,
    input  logic                wb_load_dest,
    input  lc3b_reg             wb_dest_addr,
    input  logic                kill_valid,
    input  lc3b_reg             kill_dest,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    lc3b_sb_cnt          cnt [NUM_REGS];
    logic [NUM_REGS-1:0] err_vec;
    logic                hz_a;
    logic                hz_b;
    logic                hz_full;
    logic                issue_fire;

    // No same-cycle bypass: a writeback this cycle only clears the hazard next cycle.
    assign hz_a       = src_a_used & busy_vec[src_a];
    assign hz_b       = src_b_used & busy_vec[src_b];
    assign hz_full    = issue_load_dest & (cnt[issue_dest] == SB_CNT_MAX);
    assign stall      = issue_valid & (hz_a | hz_b | hz_full);
    assign issue_fire = issue_valid & issue_load_dest & ~stall;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
        logic       inc;
        logic [1:0] dec;

        assign inc = issue_fire & (issue_dest == lc3b_reg'(i));
        assign dec = {1'b0, wb_load_dest & (wb_dest_addr == lc3b_reg'(i))}
                   + {1'b0, kill_valid & (kill_dest == lc3b_reg'(i))};

        sb_counter u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt[i]),
            .nz        (busy_vec[i]),
            .err_pulse (err_vec[i])
        );
    end

    // Sticky until reset so software can inspect a bookkeeping fault later.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|err_vec) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized scoreboard bench for id_scoreboard against a pending-write count model.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_load_dest;
    logic [2:0] issue_dest;
    logic       src_a_used;
    logic [2:0] src_a;
    logic       src_b_used;
    logic [2:0] src_b;
    logic       wb_load_dest;
    logic [2:0] wb_dest_addr;
    logic       kill_valid;
    logic [2:0] kill_dest;
    logic       stall;
    logic [7:0] busy_vec;
    logic       err;

    always #5 clk = ~clk;

    id_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_load_dest (issue_load_dest),
        .issue_dest      (issue_dest),
        .src_a_used      (src_a_used),
        .src_a           (src_a),
        .src_b_used      (src_b_used),
        .src_b           (src_b),
        .wb_load_dest    (wb_load_dest),
        .wb_dest_addr    (wb_dest_addr),
        .kill_valid      (kill_valid),
        .kill_dest       (kill_dest),
        .stall           (stall),
        .busy_vec        (busy_vec),
        .err             (err)
    );

    typedef struct {
        bit         chk;
        bit         stall;
        logic [7:0] busy;
        bit         err;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: number of writes still owed to each register.
    int m_cnt [8];
    bit m_err;
    int cycle  = 0;
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check_output(input string name, input logic [7:0] act,
                                input logic [7:0] expv, input int cyc);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit chk,
                                  input bit iv, input bit ild, input int d,
                                  input bit au, input int a, input bit bu, input int b,
                                  input bit wl, input int wd, input bit kv, input int kd);
        exp_t e;
        bit   fire;
        int   n;
        @(posedge clk);
        #1;
        cycle++;
        reset           = rst;
        issue_valid     = iv;
        issue_load_dest = ild;
        issue_dest      = 3'(d);
        src_a_used      = au;
        src_a           = 3'(a);
        src_b_used      = bu;
        src_b           = 3'(b);
        wb_load_dest    = wl;
        wb_dest_addr    = 3'(wd);
        kill_valid      = kv;
        kill_dest       = 3'(kd);

        e.chk   = chk;
        e.cyc   = cycle;
        e.err   = m_err;
        e.stall = iv && ((au && m_cnt[a] > 0) || (bu && m_cnt[b] > 0) || (ild && m_cnt[d] >= 3));
        for (int i = 0; i < 8; i++) e.busy[i] = (m_cnt[i] > 0);
        exp_q.push_back(e);

        fire = iv && ild && !e.stall;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                n = m_cnt[i] + ((fire && d == i) ? 1 : 0)
                             - ((wl && wd == i) ? 1 : 0)
                             - ((kv && kd == i) ? 1 : 0);
                if (n < 0) begin
                    n = 0;
                    m_err = 1;
                end
                if (n > 3) begin
                    n = 3;
                    m_err = 1;
                end
                m_cnt[i] = n;
            end
        end
    endtask

    task automatic idle(input bit wl, input int wd);
        apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, wl, wd, 0, 0);
    endtask

    function automatic int pick_busy();
        int r;
        r = int'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
            if (m_cnt[(r + k) % 8] > 0) return (r + k) % 8;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk) begin
                check_output("stall", {7'b0, stall}, {7'b0, mon_e.stall}, mon_e.cyc);
                check_output("busy_vec", busy_vec, mon_e.busy, mon_e.cyc);
                check_output("err", {7'b0, err}, {7'b0, mon_e.err}, mon_e.cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err = 0;

        // Reset with arbitrary inputs; the first cycle's counters are unknown.
        apply_stimulus(1, 0, 1, 1, 3, 1, 5, 1, 6, 1, 2, 1, 4);
        apply_stimulus(1, 1, 1, 1, 7, 1, 0, 0, 1, 1, 6, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);

        // Read-after-write on R3, cleared the cycle after its writeback.
        apply_stimulus(0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 1, 1, 3, 0, 0, 1, 3, 0, 0);
        apply_stimulus(0, 1, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        idle(1, 1);

        // Three writers to R5 fill the counter; a fourth waits for one writeback.
        repeat (3) apply_stimulus(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
        apply_stimulus(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle(1, 5);

        // Issue, writeback and kill on R2 in one cycle nets to zero.
        apply_stimulus(0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 2, 0, 0, 0, 0, 1, 2, 1, 2);
        idle(0, 0);

        // Store reading R4 stalls without reserving, then proceeds.
        apply_stimulus(0, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 4, 1, 1, 1, 4, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 4, 1, 1, 1, 4, 1, 4, 0, 0);
        apply_stimulus(0, 1, 1, 0, 4, 1, 1, 1, 4, 0, 0, 0, 0);
        idle(0, 0);

        // Writeback with nothing pending sets a sticky error cleared by reset.
        idle(1, 6);
        repeat (3) idle(0, 0);
        apply_stimulus(1, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            bit iv, ild, au, bu, wl, kv, rst;
            int d, a, b, wd, kd;
            rst = (c % 150 == 149);
            iv  = ($urandom_range(0, 3) != 0);
            ild = $urandom_range(0, 1);
            d   = int'($urandom_range(0, 7));
            au  = $urandom_range(0, 1);
            a   = int'($urandom_range(0, 7));
            bu  = $urandom_range(0, 1);
            b   = int'($urandom_range(0, 7));
            wl  = ($urandom_range(0, 9) < 4);
            wd  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : pick_busy();
            kv  = ($urandom_range(0, 9) == 0);
            kd  = pick_busy();
            apply_stimulus(rst, 1, iv, ild, d, au, a, bu, b, wl, wd, kv, kd);
        end

        idle(0, 0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Register scoreboard and stall controller for the decode stage of the pipelined LC-3b.
- Tracks in-flight writes to each of the 8 architectural registers, from issue at decode to regfile write at writeback.
- Raises a stall when a decoding instruction reads a register with a pending write. The decode-stage regfile has no forwarding, so the stall holds decode until the value is written back.
- Decode and pipeline-latch load enables are gated by `stall`; the block never touches regfile data.

Parameters:
- NUM_REGS, 8, number of architectural registers (index width is lc3b_reg, 3 bits).
- CNT_WIDTH, 2, width of each per-register pending-write counter; max in flight per register = 2^CNT_WIDTH-1 = 3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode holds a valid instruction trying to advance this cycle.
- issue_load_dest  in  1  that instruction writes a register (ctrl load_regfile).
- issue_dest  in  3  destination register after dest/R7 selection.
- src_a_used  in  1  instruction reads port A.
- src_a  in  3  port-A register (after store select).
- src_b_used  in  1  instruction reads port B.
- src_b  in  3  port-B register (after store select).
- wb_load_dest  in  1  writeback commits a register write this cycle.
- wb_dest_addr  in  3  register being written back.
- kill_valid  in  1  a squashed (flushed) younger instruction that had issue_load_dest releases its reservation.
- kill_dest  in  3  destination of the squashed instruction.
- stall  out  1  combinational; hold decode and insert bubble.
- busy_vec  out  8  registered; bit i = counter[i] != 0.
- err  out  1  registered, sticky; underflow or overflow detected.

Behaviour:
- State: NUM_REGS counters cnt[i] of CNT_WIDTH bits, plus the err flag.
- Reset (synchronous, dominates all other inputs, including mid-stall): all cnt = 0, busy_vec = 0, err = 0. stall is then 0 unless inputs request it on the next cycle.
- Hazard terms, all from current-cycle counter values:
  - hz_a = src_a_used & (cnt[src_a] != 0)
  - hz_b = src_b_used & (cnt[src_b] != 0)
  - hz_full = issue_load_dest & (cnt[issue_dest] == max)
- stall = issue_valid & (hz_a | hz_b | hz_full).
  - A writeback to a source register in the same cycle does not clear the stall that cycle; it clears the cycle after. Regfile read-before-write; no same-cycle bypass.
- issue_fire = issue_valid & issue_load_dest & ~stall.
- Per-register update each cycle, for each i:
  - inc = issue_fire & (issue_dest == i)
  - dec = (wb_load_dest & (wb_dest_addr == i)) + (kill_valid & (kill_dest == i)), range 0..2
  - cnt[i] next = cnt[i] + inc - dec.
  - All three events may hit the same register in one cycle; the net effect applies (e.g. cnt 1, inc + wb + kill → 0).
- Underflow: if cnt[i] + inc < dec, cnt[i] saturates at 0 and err is set.
- Overflow: cannot occur while hz_full gates issue. Any computed result > max saturates at max and sets err (defensive).
- err clears only on reset.
- busy_vec is the registered OR-reduction of each counter. It reflects post-update state, one cycle after the events.
- Latency:
  - issue → dependent instruction stalls starting the next cycle.
  - wb → stall deasserts the cycle after wb_load_dest, provided no other pending write remains on that register.
- R7 (JSR/TRAP link) is tracked like any register via issue_dest.
- Instructions with issue_load_dest = 0 (stores, branches) never reserve. They still stall on their sources.
- If issue_valid = 0, stall = 0 and no increment occurs, regardless of the source fields.

Decomposition:
- lc3b_types additions: lc3b_sb_cnt typedef (logic [CNT_WIDTH-1:0]), and constant SB_CNT_MAX.
- One natural sub-module, sb_counter, instantiated NUM_REGS times in a generate loop. It holds a single saturating up/down counter with inputs inc (1b) and dec (2b), and outputs cnt, nz and err_pulse.
- id_scoreboard holds the decode/compare logic, the stall equation and the err OR-reduction.

Test Plan:
- Reset with arbitrary inputs for 2 cycles → busy_vec = 8'h00, err = 0, stall = 0 with issue_valid = 1 and src_a_used = 1.
- Issue ADD R3 (dest 3); next cycle issue with src_a = 3, src_a_used = 1 → stall = 1. Hold it, then pulse wb_load_dest with wb_dest_addr = 3 → stall stays 1 that cycle, = 0 the following cycle; busy_vec[3] 1→0.
- Issue three writers to R5 back-to-back with no wb → cnt[5] = 3. A fourth writer to R5 → stall = 1 (hz_full). One wb to R5 → fourth issues the cycle after; cnt[5] stays 3.
- Same cycle: cnt[2] = 1, issue_fire to R2, wb to R2, kill to R2 → next cnt[2] = 0, busy_vec[2] = 0, err = 0.
- wb_load_dest to R6 with cnt[6] = 0 → cnt[6] stays 0, err = 1, and err stays 1 until reset.
- Store with src_b = dest field 4 (STR reads R4) while cnt[4] = 1, issue_load_dest = 0 → stall = 1 and no counter increments. After wb to R4, it issues with all counters unchanged.
